rnn_mem_sched: RTL
==================

# rnn_mem_sched

Memory-port scheduler inside the RNN core. It shares the single external parameter/result memory port (`mce`, `msel`, `maddr`, `mdata_w`, `mdata_r`) between two internal requesters: the parameter-fetch engine (read bursts of W_IH, B_IH, W_HH, B_HH and the sequence-length word) and the hidden-state writeback engine (write bursts, `msel`=101). It arbitrates round-robin at burst granularity, generates incrementing addresses, and returns read data with fixed one-cycle latency.

## Interface
- `AW`, 17, memory address width
- `DW`, 20, memory data width (Q-format word)
- `LW`, 13, burst-length width (max burst 4096 = one W_HH matrix)

- `clk` in 1 — core clock
- `reset` in 1 — synchronous, active-low reset
- `ra_req` in 1 — read burst request, held until `ra_gnt`
- `ra_sel` in 3 — memory select for the burst (000..100 legal)
- `ra_addr` in AW — burst base address
- `ra_len` in LW — beats in burst
- `ra_gnt` out 1 — one-cycle pulse; params latched
- `ra_rvalid` out 1 — `ra_rdata` valid this cycle
- `ra_rdata` out DW — captured read word
- `ra_done` out 1 — one-cycle pulse, burst finished
- `wb_req`, `wb_addr`, `wb_len` in 1/AW/LW — write burst request, base, length
- `wb_gnt` out 1 — one-cycle pulse
- `wb_wready` out 1 — requester must drive `wb_wdata` this cycle
- `wb_wdata` in DW — write word
- `wb_done` out 1 — one-cycle pulse
- `mce` out 1, `msel` out 3, `maddr` out AW, `mdata_w` out DW — memory port, all registered
- `mdata_r` in DW — memory read data
- `sched_busy` out 1 — high whenever state ≠ IDLE

## Operation
- States: IDLE, RD, RD_TAIL, WR, WR_TAIL.
- IDLE: requests sampled each edge. One request → grant it. Both → grant the port not served last; `last` resets to "write", so read wins first tie.
- At grant: latch sel/addr/len, clear beat counter, pulse `*_gnt` in the first cycle of the new state; the requester may drop `*_req` after gnt.
- RD: one beat per cycle, `mce`=1, `msel`=latched sel, `maddr`=base+beat. After len beats → RD_TAIL (no `mce`), then IDLE.
- Read data: `mdata_r` sampled at the edge ending each `mce` cycle into `ra_rdata`; `ra_rvalid` is the one-cycle-delayed read strobe.
- WR: `wb_wready`=1 for len cycles; each cycle's `wb_wdata` is registered into `mdata_w` with `mce`=1, `msel`=101, `maddr`=base+beat on the following cycle. No requester backpressure. After the last wready cycle → WR_TAIL (final beat on the port), then IDLE.
- Address arithmetic is modulo 2^AW: base 0x1FFFE, len 3 → 0x1FFFE, 0x1FFFF, 0x00000.
- len=0: grant, no `mce`, `*_done` in the cycle after gnt.
- Illegal `ra_sel` (101..111): grant and done as for len=0, no memory access. This keeps the read port from ever writing.
- Bursts are non-preemptible. A request arriving mid-burst waits.
- Reset (low at an edge): state IDLE, `last`=write, all outputs 0 (`mce`, `msel`, `maddr`, `mdata_w`, gnt/valid/done/wready, `ra_rdata`, `sched_busy`). An in-flight burst is abandoned with no done pulse.

## Timing
- Cycle 0 = first cycle after the grant edge.
- Read burst of length L:
  - `mce` cycles 0..L-1
  - `ra_rvalid` cycles 1..L
  - `ra_done` cycle L (coincident with the last rvalid)
  - IDLE in cycle L+1; next grant edge ends cycle L+1, next burst's cycle 0 is L+2
- Write burst of length L:
  - `wb_wready` cycles 0..L-1
  - `mce` cycles 1..L, beat k's data appears on `mdata_w` in cycle k+1
  - `wb_done` cycle L (the last `mce` cycle)
- `ra_gnt`/`wb_gnt` are never high together.
- Memory side: `mce`/`maddr` are driven from the rising edge and sampled by the memory on the falling edge. `mdata_r` is stable at the next rising edge.

## Test plan
- Read ra_sel=001, addr 0, len 4 after reset → `mce` cycles 0-3, `maddr` 0,1,2,3, `ra_rvalid` cycles 1-4 with B_IH[0..3], `ra_done` cycle 4, `sched_busy` 0 in cycle 5.
- ra_sel=100, len 1 → `ra_rdata`=20'd200 in cycle 1, done cycle 1.
- `ra_req` and `wb_req` raised together, 3 back-to-back pairs → grants alternate R,W,R,W,R,W. Never two gnts in one cycle. No port activity overlaps.
- Write wb_addr 0x1FFFE, len 3, wdata 0xA0001/2/3 → `msel`=101 at `maddr` 0x1FFFE, 0x1FFFF, 0x00000 with matching data in cycles 1-3, `wb_done` cycle 3.
- len=0 read and ra_sel=101 read → gnt then done next cycle, `mce` stays 0.
- `reset` low in cycle 2 of a len-8 read → all outputs 0 on the next cycle, no `ra_done`. A following tie grants the read port first.

Source files
------------

// File: rtl/rnn_mem_sched.sv
// Memory-port scheduler: shares the external parameter/result memory port between
// the parameter-fetch read engine and the hidden-state writeback engine.
`timescale 1ns/1ps

module rnn_mem_sched #(
  parameter int AW = 17,
  parameter int DW = 20,
  parameter int LW = 13
) (
  input  logic          clk,
  input  logic          reset,
  // read requester (parameter fetch)
  input  logic          ra_req,
  input  logic [2:0]    ra_sel,
  input  logic [AW-1:0] ra_addr,
  input  logic [LW-1:0] ra_len,
  output logic          ra_gnt,
  output logic          ra_rvalid,
  output logic [DW-1:0] ra_rdata,
  output logic          ra_done,
  // write requester (hidden-state writeback)
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [LW-1:0] wb_len,
  output logic          wb_gnt,
  output logic          wb_wready,
  input  logic [DW-1:0] wb_wdata,
  output logic          wb_done,
  // external memory port
  output logic          mce,
  output logic [2:0]    msel,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  input  logic [DW-1:0] mdata_r,
  output logic          sched_busy,
  output logic [2:0]    o_dbg_state
);

  // Handshake: *_req is a level held until the one-cycle *_gnt pulse, after which the
  // burst runs at a fixed rate with no backpressure; ra_rvalid qualifies ra_rdata, and
  // wb_wready marks the cycles whose wb_wdata is consumed at the closing clock edge.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_TAIL = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_TAIL = 3'd4;

  localparam logic [2:0] SEL_WB      = 3'b101;
  localparam logic [2:0] SEL_LAST_RD = 3'b100;

  logic [2:0]    r_state;
  logic          r_last_wr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_beat;
  logic [AW-1:0] r_next_addr;

  logic          r_mce;
  logic [2:0]    r_msel;
  logic [AW-1:0] r_maddr;
  logic [DW-1:0] r_mdata_w;

  logic          r_ra_gnt;
  logic          r_ra_rvalid;
  logic [DW-1:0] r_ra_rdata;
  logic          r_ra_done;
  logic          r_wb_gnt;
  logic          r_wb_wready;
  logic          r_wb_done;

  logic w_ra_legal;
  logic w_ra_access;
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_rd_strobe;

  // Illegal selects collapse to a zero-length burst so the read port can never write.
  assign w_ra_legal  = (ra_sel <= SEL_LAST_RD);
  assign w_ra_access = w_ra_legal && (ra_len != '0);

  // On a tie the port not served last wins.
  assign w_grant_rd  = ra_req && (!wb_req || r_last_wr);
  assign w_grant_wr  = wb_req && !w_grant_rd;

  assign w_rd_strobe = r_mce && (r_state == S_RD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last_wr   <= 1'b1;
      r_len       <= '0;
      r_beat      <= '0;
      r_next_addr <= '0;
      r_mce       <= 1'b0;
      r_msel      <= '0;
      r_maddr     <= '0;
      r_mdata_w   <= '0;
      r_ra_gnt    <= 1'b0;
      r_ra_rvalid <= 1'b0;
      r_ra_rdata  <= '0;
      r_ra_done   <= 1'b0;
      r_wb_gnt    <= 1'b0;
      r_wb_wready <= 1'b0;
      r_wb_done   <= 1'b0;
    end else begin
      r_ra_gnt    <= 1'b0;
      r_wb_gnt    <= 1'b0;
      r_ra_done   <= 1'b0;
      r_wb_done   <= 1'b0;
      r_ra_rvalid <= w_rd_strobe;
      if (w_rd_strobe) begin
        r_ra_rdata <= mdata_r;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_rd) begin
            r_state     <= S_RD;
            r_last_wr   <= 1'b0;
            r_ra_gnt    <= 1'b1;
            r_len       <= w_ra_legal ? ra_len : '0;
            r_next_addr <= ra_addr + AW'(1);
            if (w_ra_access) begin
              // First beat goes out in the grant cycle itself.
              r_mce   <= 1'b1;
              r_msel  <= ra_sel;
              r_maddr <= ra_addr;
              r_beat  <= LW'(1);
            end else begin
              r_beat  <= '0;
            end
          end else if (w_grant_wr) begin
            r_state     <= S_WR;
            r_last_wr   <= 1'b1;
            r_wb_gnt    <= 1'b1;
            r_len       <= wb_len;
            r_next_addr <= wb_addr;
            r_wb_wready <= (wb_len != '0);
            r_beat      <= (wb_len != '0) ? LW'(1) : '0;
          end
        end

        S_RD: begin
          if (r_beat == r_len) begin
            r_mce     <= 1'b0;
            r_msel    <= '0;
            r_maddr   <= '0;
            r_ra_done <= 1'b1;
            r_state   <= S_RD_TAIL;
          end else begin
            r_mce       <= 1'b1;
            r_maddr     <= r_next_addr;
            r_next_addr <= r_next_addr + AW'(1);
            r_beat      <= r_beat + LW'(1);
          end
        end

        S_RD_TAIL: begin
          r_state <= S_IDLE;
        end

        S_WR: begin
          // Data accepted under wready goes onto the port one cycle later.
          if (r_wb_wready) begin
            r_mce       <= 1'b1;
            r_msel      <= SEL_WB;
            r_maddr     <= r_next_addr;
            r_mdata_w   <= wb_wdata;
            r_next_addr <= r_next_addr + AW'(1);
          end else begin
            r_mce     <= 1'b0;
            r_msel    <= '0;
            r_maddr   <= '0;
            r_mdata_w <= '0;
          end
          if (r_beat == r_len) begin
            r_wb_wready <= 1'b0;
            r_wb_done   <= 1'b1;
            r_state     <= S_WR_TAIL;
          end else begin
            r_beat <= r_beat + LW'(1);
          end
        end

        S_WR_TAIL: begin
          r_mce     <= 1'b0;
          r_msel    <= '0;
          r_maddr   <= '0;
          r_mdata_w <= '0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ra_gnt      = r_ra_gnt;
  assign ra_rvalid   = r_ra_rvalid;
  assign ra_rdata    = r_ra_rdata;
  assign ra_done     = r_ra_done;
  assign wb_gnt      = r_wb_gnt;
  assign wb_wready   = r_wb_wready;
  assign wb_done     = r_wb_done;
  assign mce         = r_mce;
  assign msel        = r_msel;
  assign maddr       = r_maddr;
  assign mdata_w     = r_mdata_w;
  assign sched_busy  = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
